// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter driving a shared 2:1 data mux. Grants are capped at MAX_BURST transfers
// while the other side waits. The selected word is registered out with a one-cycle valid strobe.
module mux_arbiter_rr #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             req0,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic             out_ready,
  output logic             grant0,
  output logic             grant1,
  output logic             selector,
  output logic [WIDTH-1:0] dataOut,
  output logic             valid_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0]       state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             last_served, last_nxt;
  logic             own_req, oth_req, xfer;
  logic [1:0]       other;
  logic [WIDTH-1:0] sel_data;

  // Grants and the mux select decode straight from the state register, so they never glitch
  // or overlap.
  assign grant0   = (state == GNT0);
  assign grant1   = (state == GNT1);
  assign selector = grant1;

  assign own_req  = selector ? req1 : req0;
  assign oth_req  = selector ? req0 : req1;
  assign other    = selector ? GNT0 : GNT1;
  assign sel_data = selector ? dataIn1 : dataIn0;
  assign xfer     = (grant0 | grant1) & own_req & out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_served;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_served)) state_nxt = GNT0;
        else if (req1)                      state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!own_req) begin
          state_nxt = oth_req ? other : IDLE;
          cnt_nxt   = 4'd0;
        end else if (xfer) begin
          last_nxt = grant1;
          // A full burst hands over at once if the other side waits.
          // Otherwise the count restarts and the burst is renewed.
          if (cnt == BURST_LAST) begin
            cnt_nxt = 4'd0;
            if (oth_req) state_nxt = other;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_served <= 1'b1;
      dataOut     <= '0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_served <= last_nxt;
      valid_out   <= xfer;
      if (xfer) dataOut <= sel_data;
    end
  end

endmodule

// File: doc/mux_arbiter_rr.md
Name: mux_arbiter_rr

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 data multiplexer (dataIn0/dataIn1 selected by selector).
- Two requesters compete for the mux. The block drives the mux selector, grants one requester at a time, and limits each grant to a burst of MAX_BURST transfers.
- It registers the selected word into a single output register with a valid strobe, and honours downstream backpressure through out_ready.

Parameters:
- WIDTH, 8, data width of each requester and of data_out.
- MAX_BURST, 4, maximum consecutive transfers per grant while the other requester waits (range 1..15).

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 has data to send.
- dataIn0  input  WIDTH  requester 0 data word.
- req1  input  1  requester 1 has data to send.
- dataIn1  input  WIDTH  requester 1 data word.
- out_ready  input  1  downstream can accept a word this cycle.
- grant0  output  1  requester 0 owns the mux; registered.
- grant1  output  1  requester 1 owns the mux; registered.
- selector  output  1  mux select: 0 = dataIn0, 1 = dataIn1. Equals grant1.
- dataOut  output  WIDTH  last transferred word; registered.
- valid_out  output  1  one-cycle strobe, high in the cycle after each transfer.

Behaviour:
- Reset (reset_L low, any time, asynchronous) sets the following, and an in-flight burst is abandoned:
  - state = IDLE; grant0 = grant1 = 0; selector = 0
  - dataOut = 0; valid_out = 0; burst counter = 0
  - last_served = 1, so requester 0 wins the first tie.
- States: IDLE, GNT0, GNT1. grant0 = (state == GNT0); grant1 = (state == GNT1). Grants never overlap.
- IDLE:
  - Only req0 high -> GNT0. Only req1 high -> GNT1.
  - Both high -> grant the requester that is not last_served.
  - Neither high -> stay in IDLE.
  - Grant rises one cycle after the request is sampled. No transfer occurs in IDLE.
- GNTx, transfer cycle (reqx = 1 and out_ready = 1):
  - dataOut <= dataInx; valid_out <= 1 on the next edge.
  - Burst counter increments; last_served <= x.
- GNTx, stall cycle (reqx = 1 and out_ready = 0):
  - No transfer; counter holds; dataOut holds; valid_out <= 0.
- valid_out is low on every edge that follows a non-transfer cycle. dataOut holds its value between transfers.
- Leaving GNTx, evaluated on each edge:
  - reqx = 0 -> go to GNTy if reqy = 1, else IDLE. Counter <= 0.
  - A transfer makes the counter reach MAX_BURST and reqy = 1 -> go directly to GNTy. Counter <= 0. No idle bubble.
  - A transfer makes the counter reach MAX_BURST and reqy = 0 -> stay in GNTx. Counter <= 0, which renews the burst.
  - Otherwise stay in GNTx.
- Handover GNTx -> GNTy: selector switches on the same edge as the grant. The first transfer for y can occur in the cycle after the switch.
- Throughput: one word per cycle while granted with out_ready = 1. Latency from a transfer cycle to valid_out/dataOut is 1 clock.
- Counter width is 4 bits. The counter never exceeds MAX_BURST; wrap-around is impossible by construction.

Test Plan:
- Reset: reset_L = 0 mid-burst -> on the same edge window all outputs are 0, state is IDLE, selector = 0; after release, behaviour is identical to power-up.
- Single requester: req0 = 1 with dataIn0 = 0x11, 0x22, 0x33 on consecutive cycles, out_ready = 1 -> grant0 rises one cycle after req0; valid_out is high 3 cycles with dataOut = 0x11, 0x22, 0x33; selector stays 0.
- Tie after reset: req0 = req1 = 1 in the same cycle -> GNT0 first. After 4 transfers, switch directly to GNT1 (selector = 1) with no IDLE cycle. After 4 more transfers, switch back to GNT0.
- Backpressure: in GNT1, out_ready = 0 for 3 cycles -> valid_out = 0, dataOut holds, counter holds. After out_ready = 1, the burst completes with exactly MAX_BURST transfers in total.
- Early release: req0 drops after 2 transfers while req1 = 1 -> next state is GNT1 with counter 0. With req1 = 0 instead, the next state is IDLE.
- Burst renewal: req1 alone held for 10 cycles, out_ready = 1 -> grant1 stays high throughout; 10 consecutive valid_out strobes occur.
